arp_decode: RTL and testbench

// Receive-side ARP parser: consumes the MAC RX payload nibble stream (EtherType already

---
 rtl/arp_decode.sv | 123 ++++++++++++
 tb/tb_arp_decode.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_decode.sv
// Receive-side ARP request parser: walks the payload nibble stream, validates the fixed
// header fields, and hands the sender's SHA/SPA to the reply encoder when TPA is ours.
module arp_decode #(
  parameter logic [31:0] IP_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [3:0]  din,
  input  logic        din_last,
  input  logic        req_ready,
  output logic        req_valid,
  output logic [47:0] sha,
  output logic [31:0] spa,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [5:0]  nib_cnt, nib_cnt_nxt;
  logic [47:0] sha_sh;
  logic [31:0] spa_sh, tpa_sh, tpa_full;
  logic [5:0]  sha_pos;
  logic [2:0]  spa_k;
  logic [4:0]  spa_pos, tpa_pos;
  logic        fixed_ok, commit, drop, overrun, handshake;

  // Expected nibble for HTYPE/PTYPE/HLEN/PLEN/OPER(request), low nibble of each byte first.
  function automatic logic [3:0] fixed_nib(input logic [3:0] idx);
    case (idx)
      4'd2:    fixed_nib = 4'h1;
      4'd4:    fixed_nib = 4'h8;
      4'd8:    fixed_nib = 4'h6;
      4'd10:   fixed_nib = 4'h4;
      4'd14:   fixed_nib = 4'h1;
      default: fixed_nib = 4'h0;
    endcase
  endfunction

  // Bit offset of the incoming nibble inside each MSB-first field.
  assign sha_pos = 6'd40 - {nib_cnt[3:1], 3'b000} + {3'b000, nib_cnt[0], 2'b00};
  assign spa_k   = nib_cnt[2:0] - 3'd4;
  assign spa_pos = 5'd24 - {spa_k[2:1], 3'b000} + {2'b00, spa_k[0], 2'b00};
  assign tpa_pos = 5'd24 - {nib_cnt[2:1], 3'b000} + {2'b00, nib_cnt[0], 2'b00};

  assign fixed_ok  = (nib_cnt[5:4] != 2'b00) || (din == fixed_nib(nib_cnt[3:0]));
  assign handshake = req_valid && req_ready;
  assign overrun   = commit && req_valid && !req_ready;

  always_comb begin
    tpa_full      = tpa_sh;
    tpa_full[7:4] = din;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    nib_cnt_nxt = nib_cnt;
    commit      = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE, RECV: begin
        if (din_valid) begin
          if (!fixed_ok) begin
            drop        = 1'b1;
            nib_cnt_nxt = '0;
            state_nxt   = din_last ? IDLE : DRAIN;
          end else if (nib_cnt == 6'd55) begin
            commit      = (tpa_full == IP_ADDR);
            nib_cnt_nxt = '0;
            state_nxt   = din_last ? IDLE : DRAIN;
          end else if (din_last) begin
            drop        = 1'b1;
            nib_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            nib_cnt_nxt = nib_cnt + 6'd1;
            state_nxt   = RECV;
          end
        end
      end
      DRAIN: if (din_valid && din_last) state_nxt = IDLE;
      default: begin
        state_nxt   = IDLE;
        nib_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      nib_cnt   <= '0;
      req_valid <= 1'b0;
      sha       <= '0;
      spa       <= '0;
      drop_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      nib_cnt <= nib_cnt_nxt;
      if (commit && (!req_valid || req_ready)) begin
        req_valid <= 1'b1;
        sha       <= sha_sh;
        spa       <= spa_sh;
      end else if (handshake) begin
        req_valid <= 1'b0;
      end
      if ((drop || overrun) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // NOTE: shadow registers are not reset; each is fully rewritten before a commit reads it.
  always_ff @(posedge clk) begin
    if (din_valid && state != DRAIN) begin
      if (nib_cnt >= 6'd16 && nib_cnt <= 6'd27) sha_sh[sha_pos +: 4] <= din;
      if (nib_cnt >= 6'd28 && nib_cnt <= 6'd35) spa_sh[spa_pos +: 4] <= din;
      if (nib_cnt >= 6'd48 && nib_cnt <= 6'd54) tpa_sh[tpa_pos +: 4] <= din;
    end
  end

endmodule

// File: tb/tb_arp_decode.sv
// Scoreboard bench for arp_decode: expected SHA/SPA pairs are queued as frames are driven
// and popped when the encoder-side handshake occurs.
module tb_arp_decode;

  localparam logic [31:0] IP = 32'hC0A8_0105;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid, din_last, req_ready;
  logic [3:0]  din;
  logic        req_valid;
  logic [47:0] sha;
  logic [31:0] spa;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;
  int rv_high_cnt = 0;
  logic [79:0] sb_q[$];

  arp_decode #(.IP_ADDR(IP)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_last(din_last),
    .req_ready(req_ready), .req_valid(req_valid), .sha(sha), .spa(spa), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Observes the request port every cycle: pops on handshake, checks stability while pending.
  task automatic monitor();
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [79:0] prev_out = '0;
    logic [79:0] exp_out;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        prev_valid = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (req_valid) rv_high_cnt++;
        if (req_valid && prev_valid && !prev_hs) begin
          total++;
          if ({sha, spa} !== prev_out) begin
            bad++;
            $display("FAIL stable_out: got %h expected %h", {sha, spa}, prev_out);
          end
        end
        if (req_valid && req_ready) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got %h expected no request", {sha, spa});
          end else begin
            exp_out = sb_q.pop_front();
            if ({sha, spa} !== exp_out) begin
              bad++;
              $display("FAIL sb_req: got %h expected %h", {sha, spa}, exp_out);
            end
          end
        end
        prev_valid = req_valid;
        prev_hs = req_valid && req_ready;
        prev_out = {sha, spa};
      end
    end
  endtask

  task automatic drive_frame(input logic [47:0] s_ha, input logic [31:0] s_pa,
                             input logic [31:0] t_pa, input logic [15:0] op,
                             input int n_send, input bit last, input int ready_at,
                             input bit gaps);
    logic [7:0] b[28];
    b[0] = 8'h00; b[1] = 8'h01; b[2] = 8'h08; b[3] = 8'h00;
    b[4] = 8'h06; b[5] = 8'h04; b[6] = op[15:8]; b[7] = op[7:0];
    for (int i = 0; i < 6; i++) b[8 + i]  = s_ha[47 - 8 * i -: 8];
    for (int i = 0; i < 4; i++) b[14 + i] = s_pa[31 - 8 * i -: 8];
    for (int i = 0; i < 6; i++) b[18 + i] = 8'hA5;
    for (int i = 0; i < 4; i++) b[24 + i] = t_pa[31 - 8 * i -: 8];
    for (int i = 0; i < n_send; i++) begin
      if (gaps && (i % 7) == 3) begin
        @(negedge clk);
        din_valid = 1'b0;
        din_last  = 1'b0;
      end
      @(negedge clk);
      if (i == ready_at) req_ready = 1'b1;
      din_valid = 1'b1;
      if (i < 56) din = i[0] ? b[i / 2][7:4] : b[i / 2][3:0];
      else        din = 4'h0;
      din_last = last && (i == n_send - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; din_valid = 1'b0; din_last = 1'b0; din = 4'h0; req_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_valid, sha, spa, drop_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_out: got %h expected 0", {req_valid, sha, spa, drop_cnt});
    end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    req_ready = 1'b1;
    rv_high_cnt = 0;
    sb_q.push_back({48'h020000000001, 32'h0A000001});
    drive_frame(48'h020000000001, 32'h0A000001, IP, 16'h0001, 56, 1'b1, -1, 1'b0);
    idle(1);
    total++;
    if (req_valid !== 1'b1 || sha !== 48'h020000000001 || spa !== 32'h0A000001) begin
      bad++;
      $display("FAIL single_commit: got v=%b %h/%h expected v=1 020000000001/0a000001",
               req_valid, sha, spa);
    end
    idle(3);
    total++;
    if (rv_high_cnt != 1 || req_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse: got %0d cycles v=%b expected 1 cycles v=0",
               rv_high_cnt, req_valid);
    end
  endtask

  task automatic test_hold();
    req_ready = 1'b0;
    rv_high_cnt = 0;
    sb_q.push_back({48'h0A1B2C3D4E5F, 32'hC0A80002});
    drive_frame(48'h0A1B2C3D4E5F, 32'hC0A80002, IP, 16'h0001, 92, 1'b1, 65, 1'b0);
    idle(3);
    total++;
    if (rv_high_cnt != 10) begin
      bad++;
      $display("FAIL hold_cycles: got %0d expected 10", rv_high_cnt);
    end
    total++;
    if (drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL hold_drain: got drop_cnt=%0d expected 0", drop_cnt);
    end
  endtask

  task automatic test_reply();
    req_ready = 1'b1;
    rv_high_cnt = 0;
    drive_frame(48'h111111111111, 32'h0A000009, IP, 16'h0002, 66, 1'b1, -1, 1'b0);
    idle(3);
    total++;
    if (drop_cnt !== 8'd1 || rv_high_cnt != 0) begin
      bad++;
      $display("FAIL reply_drop: got drop=%0d v_cycles=%0d expected drop=1 v_cycles=0",
               drop_cnt, rv_high_cnt);
    end
  endtask

  task automatic test_other_tpa();
    rv_high_cnt = 0;
    drive_frame(48'h222222222222, 32'h0A000002, IP + 32'd1, 16'h0001, 56, 1'b1, -1, 1'b0);
    idle(3);
    total++;
    if (drop_cnt !== 8'd1 || rv_high_cnt != 0) begin
      bad++;
      $display("FAIL other_tpa: got drop=%0d v_cycles=%0d expected drop=1 v_cycles=0",
               drop_cnt, rv_high_cnt);
    end
  endtask

  task automatic test_back_to_back();
    req_ready = 1'b0;
    sb_q.push_back({48'hAABBCCDDEEFF, 32'h0A000003});
    drive_frame(48'hAABBCCDDEEFF, 32'h0A000003, IP, 16'h0001, 56, 1'b1, -1, 1'b0);
    drive_frame(48'h123456789ABC, 32'h0A000004, IP, 16'h0001, 56, 1'b1, -1, 1'b0);
    idle(2);
    total++;
    if (drop_cnt !== 8'd2 || req_valid !== 1'b1 || sha !== 48'hAABBCCDDEEFF ||
        spa !== 32'h0A000003) begin
      bad++;
      $display("FAIL overrun: got drop=%0d v=%b %h/%h expected drop=2 v=1 aabbccddeeff/0a000003",
               drop_cnt, req_valid, sha, spa);
    end
    @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_valid !== 1'b0) begin
      bad++;
      $display("FAIL overrun_release: got v=%b expected 0", req_valid);
    end
  endtask

  task automatic test_short_and_reset();
    req_ready = 1'b1;
    drive_frame(48'h333333333333, 32'h0A000005, IP, 16'h0001, 21, 1'b1, -1, 1'b0);
    idle(1);
    total++;
    if (drop_cnt !== 8'd3) begin
      bad++;
      $display("FAIL short_drop: got %0d expected 3", drop_cnt);
    end
    drive_frame(48'h444444444444, 32'h0A000006, IP, 16'h0001, 30, 1'b0, -1, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({req_valid, sha, spa, drop_cnt} !== '0) begin
      bad++;
      $display("FAIL midframe_reset: got %h expected 0", {req_valid, sha, spa, drop_cnt});
    end
    rst = 1'b1;
    @(negedge clk);
    din_last = 1'b1;
    @(negedge clk);
    din_last = 1'b0;
    sb_q.push_back({48'h5C6D7E8F9012, 32'hC0A80107});
    drive_frame(48'h5C6D7E8F9012, 32'hC0A80107, IP, 16'h0001, 56, 1'b1, -1, 1'b1);
    idle(1);
    total++;
    if (req_valid !== 1'b1 || sha !== 48'h5C6D7E8F9012 || spa !== 32'hC0A80107 ||
        drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL post_reset: got v=%b %h/%h drop=%0d expected v=1 5c6d7e8f9012/c0a80107 drop=0",
               req_valid, sha, spa, drop_cnt);
    end
    idle(2);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din = 4'hF;
      din_last = 1'b1;
    end
    idle(2);
    total++;
    if (drop_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL drop_saturate: got %h expected ff", drop_cnt);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_hold();
    test_reply();
    test_other_tpa();
    test_back_to_back();
    test_short_and_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
